// File: rtl/asrm_ram_lane_responder_pkg.sv
// rtl/asrm_ram_lane_responder_pkg.sv - shared size/state encodings and width rules for the lane responder
package asrm_ram_lane_responder_pkg;

  typedef enum logic [1:0] {
    SZ_FULL = 2'b00,
    SZ_W32  = 2'b01,
    SZ_W16  = 2'b10,
    SZ_W8   = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_ISSUE = 3'd1,
    ST_RD_WAIT  = 3'd2,
    ST_WR_MERGE = 3'd3,
    ST_DONE     = 3'd4
  } state_e;

  // Also used by the CPU-side reduced-behaviour logic, so keep the rule in one place.
  function automatic logic is_reduced(input int unsigned n_bytes, input int unsigned ws);
    return (8 * n_bytes) < ws;
  endfunction

  function automatic int unsigned access_bytes(input size_e sz, input int unsigned ws);
    int unsigned n;
    case (sz)
      SZ_W32:  n = 4;
      SZ_W16:  n = 2;
      SZ_W8:   n = 1;
      default: n = ws / 8;
    endcase
    if (!is_reduced(n, ws)) n = ws / 8;
    return n;
  endfunction

endpackage

// File: rtl/asrm_lane_merge.sv
// rtl/asrm_lane_merge.sv - byte-lane extract (zero-extended) and lane merge for narrow accesses
module asrm_lane_merge #(
  parameter int wordsize = 16,
  parameter int LW       = 1
) (
  input  logic [wordsize-1:0] i_word,
  input  logic [wordsize-1:0] i_data,
  input  logic [LW-1:0]       i_lane,
  input  logic [4:0]          i_nbytes,
  output logic [wordsize-1:0] o_extract,
  output logic [wordsize-1:0] o_merged
);

  logic [7:0]          w_shift;
  logic [7:0]          w_nbits;
  logic [wordsize-1:0] w_mask;

  assign w_shift = 8'({i_lane, 3'b000});
  assign w_nbits = 8'({i_nbytes, 3'b000});
  // Shifting by the full width yields zero, so a full-word access gets an all-ones mask.
  assign w_mask  = ~({wordsize{1'b1}} << w_nbits);

  assign o_extract = (i_word >> w_shift) & w_mask;
  assign o_merged  = (i_word & ~(w_mask << w_shift)) | ((i_data & w_mask) << w_shift);

endmodule

// File: rtl/asrm_ram_lane_responder.sv
// rtl/asrm_ram_lane_responder.sv - converts byte-addressed 8/16/32-bit/full CPU accesses into RAM word accesses
module asrm_ram_lane_responder
  import asrm_ram_lane_responder_pkg::*;
#(
  parameter int wordsize = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [wordsize-1:0] addr,
  input  logic                read_en,
  input  logic                write_en,
  input  logic [1:0]          reduced_behavior_bits,
  input  logic [wordsize-1:0] data_out_cpu,
  output logic [wordsize-1:0] data_in_cpu,
  output logic                ready,
  output logic                busy,
  output logic [wordsize-1:0] ram_addr,
  output logic                ram_enable,
  output logic                ram_write_en,
  output logic [wordsize-1:0] ram_data_out,
  input  logic [wordsize-1:0] ram_data_in
);

  localparam int B  = wordsize / 8;
  localparam int SH = $clog2(B);
  localparam int LW = (B > 1) ? $clog2(B) : 1;

  state_e              r_state, w_next;
  logic [wordsize-1:0] r_word_idx, r_data, r_rd_word, r_data_in_cpu;
  logic [LW-1:0]       r_lane;
  logic [4:0]          r_n;
  logic                r_write;

  logic [4:0]          w_n;
  logic                w_full, w_accept, w_is_write;
  logic [LW-1:0]       w_lane_raw, w_lane;
  logic [wordsize-1:0] w_word_idx, w_lane_word, w_extract, w_merged;

  assign w_n        = 5'(access_bytes(size_e'(reduced_behavior_bits), wordsize));
  assign w_full     = (w_n == 5'(B));
  assign w_word_idx = addr >> SH;
  assign w_lane_raw = addr[LW-1:0] & LW'(B - 1);
  assign w_lane     = w_lane_raw & ~LW'(w_n - 5'd1);
  // Gated by reset so an asserted reset also cancels the combinational full-write strobe.
  assign w_accept   = reset && (r_state == ST_IDLE) && (read_en || write_en);
  assign w_is_write = write_en;

  assign w_lane_word = (r_state == ST_WR_MERGE) ? r_rd_word : ram_data_in;

  asrm_lane_merge #(.wordsize(wordsize), .LW(LW)) u_lane_merge (
    .i_word    (w_lane_word),
    .i_data    (r_data),
    .i_lane    (r_lane),
    .i_nbytes  (r_n),
    .o_extract (w_extract),
    .o_merged  (w_merged)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_word_idx    <= '0;
      r_data        <= '0;
      r_rd_word     <= '0;
      r_data_in_cpu <= '0;
      r_lane        <= '0;
      r_n           <= '0;
      r_write       <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_word_idx <= w_word_idx;
        r_data     <= data_out_cpu;
        r_lane     <= w_lane;
        r_n        <= w_n;
        r_write    <= w_is_write;
      end
      if (r_state == ST_RD_WAIT) begin
        if (r_write) r_rd_word     <= ram_data_in;
        else         r_data_in_cpu <= w_extract;
      end
    end
  end

  always_comb begin
    w_next       = r_state;
    ram_enable   = 1'b0;
    ram_write_en = 1'b0;
    ram_addr     = '0;
    ram_data_out = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_is_write && w_full) begin
            ram_enable   = 1'b1;
            ram_write_en = 1'b1;
            ram_addr     = w_word_idx;
            ram_data_out = data_out_cpu;
            w_next       = ST_DONE;
          end else begin
            w_next = ST_RD_ISSUE;
          end
        end
      end
      ST_RD_ISSUE: begin
        ram_enable = 1'b1;
        ram_addr   = r_word_idx;
        w_next     = ST_RD_WAIT;
      end
      ST_RD_WAIT: w_next = r_write ? ST_WR_MERGE : ST_DONE;
      ST_WR_MERGE: begin
        ram_enable   = 1'b1;
        ram_write_en = 1'b1;
        ram_addr     = r_word_idx;
        ram_data_out = w_merged;
        w_next       = ST_DONE;
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  assign data_in_cpu = r_data_in_cpu;
  assign ready       = (r_state == ST_DONE);
  assign busy        = (r_state == ST_RD_ISSUE) || (r_state == ST_RD_WAIT) || (r_state == ST_WR_MERGE);

endmodule

// File: tb/tb_asrm_ram_lane_responder.sv
// tb/tb_asrm_ram_lane_responder.sv - directed bench for the lane responder at wordsize 32 and 16
module tb_asrm_ram_lane_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [31:0] a_addr, a_dout, a_din, a_ram_addr, a_ram_dout, a_ram_din;
  logic        a_rd, a_wr, a_ready, a_busy, a_ram_en, a_ram_we;
  logic [1:0]  a_bits;
  logic [15:0] b_addr, b_dout, b_din, b_ram_addr, b_ram_dout, b_ram_din;
  logic        b_rd, b_wr, b_ready, b_busy, b_ram_en, b_ram_we;
  logic [1:0]  b_bits;

  asrm_ram_lane_responder #(.wordsize(32)) dut32 (
    .clk(clk), .reset(rst_n), .addr(a_addr), .read_en(a_rd), .write_en(a_wr),
    .reduced_behavior_bits(a_bits), .data_out_cpu(a_dout), .data_in_cpu(a_din),
    .ready(a_ready), .busy(a_busy), .ram_addr(a_ram_addr), .ram_enable(a_ram_en),
    .ram_write_en(a_ram_we), .ram_data_out(a_ram_dout), .ram_data_in(a_ram_din)
  );

  asrm_ram_lane_responder #(.wordsize(16)) dut16 (
    .clk(clk), .reset(rst_n), .addr(b_addr), .read_en(b_rd), .write_en(b_wr),
    .reduced_behavior_bits(b_bits), .data_out_cpu(b_dout), .data_in_cpu(b_din),
    .ready(b_ready), .busy(b_busy), .ram_addr(b_ram_addr), .ram_enable(b_ram_en),
    .ram_write_en(b_ram_we), .ram_data_out(b_ram_dout), .ram_data_in(b_ram_din)
  );

  logic [31:0] mem32 [0:15];
  logic [15:0] mem16 [0:7];
  int          n_rd32 = 0, n_wr32 = 0;
  logic [31:0] last_rd_addr32 = '0;

  always @(posedge clk) begin
    if (a_ram_en) begin
      if (a_ram_we) begin
        mem32[a_ram_addr[3:0]] <= a_ram_dout;
        n_wr32 <= n_wr32 + 1;
      end else begin
        a_ram_din      <= mem32[a_ram_addr[3:0]];
        last_rd_addr32 <= a_ram_addr;
        n_rd32         <= n_rd32 + 1;
      end
    end
    if (b_ram_en) begin
      if (b_ram_we) mem16[b_ram_addr[2:0]] <= b_ram_dout;
      else          b_ram_din <= mem16[b_ram_addr[2:0]];
    end
  end

  task automatic req32(input logic rd, input logic wr, input logic [1:0] bits,
                       input logic [31:0] a, input logic [31:0] d, output int lat);
    @(negedge clk);
    while (a_ready || a_busy) @(negedge clk);
    a_rd = rd; a_wr = wr; a_bits = bits; a_addr = a; a_dout = d;
    @(posedge clk); #1;
    a_rd = 1'b0; a_wr = 1'b0;
    lat = 1;
    while (!a_ready && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic req16(input logic rd, input logic wr, input logic [1:0] bits,
                       input logic [15:0] a, input logic [15:0] d, output int lat);
    @(negedge clk);
    while (b_ready || b_busy) @(negedge clk);
    b_rd = rd; b_wr = wr; b_bits = bits; b_addr = a; b_dout = d;
    @(posedge clk); #1;
    b_rd = 1'b0; b_wr = 1'b0;
    lat = 1;
    while (!b_ready && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    a_rd = 1'b0; a_wr = 1'b1; a_bits = 2'b00; a_addr = 32'd8; a_dout = 32'hFFFF_FFFF;
    b_rd = 1'b0; b_wr = 1'b0; b_bits = 2'b00; b_addr = '0; b_dout = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({a_ram_en, a_ram_we, a_ready, a_busy} !== 4'b0000) begin
      failures++; $display("FAIL reset_strobes got=%b want=0000", {a_ram_en, a_ram_we, a_ready, a_busy});
    end
    checks++;
    if (a_din !== 32'h0 || a_ram_addr !== 32'h0 || a_ram_dout !== 32'h0) begin
      failures++; $display("FAIL reset_data din=%h ram_addr=%h ram_dout=%h want=0", a_din, a_ram_addr, a_ram_dout);
    end
    checks++;
    if (b_din !== 16'h0 || b_ready !== 1'b0 || b_busy !== 1'b0) begin
      failures++; $display("FAIL reset_ws16 din=%h ready=%b busy=%b want=0", b_din, b_ready, b_busy);
    end
    a_wr = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_narrow_write;
    int lat, rd0, wr0;
    rd0 = n_rd32; wr0 = n_wr32;
    req32(1'b0, 1'b1, 2'b11, 32'd5, 32'h0000_00AB, lat);
    checks++;
    if (lat !== 4) begin failures++; $display("FAIL nw_latency got=%0d want=4", lat); end
    @(posedge clk); #1;
    checks++;
    if (a_ready !== 1'b0) begin failures++; $display("FAIL nw_ready_pulse got=%b want=0", a_ready); end
    checks++;
    if (mem32[1] !== 32'h1122AB44) begin failures++; $display("FAIL nw_word got=%h want=1122ab44", mem32[1]); end
    checks++;
    if (n_rd32 - rd0 !== 1 || n_wr32 - wr0 !== 1) begin
      failures++; $display("FAIL nw_ram_ops rd=%0d wr=%0d want=1/1", n_rd32 - rd0, n_wr32 - wr0);
    end
    checks++;
    if (a_din !== 32'h0) begin failures++; $display("FAIL nw_din_kept got=%h want=0", a_din); end
  endtask

  task automatic test_narrow_read;
    int lat;
    req32(1'b1, 1'b0, 2'b10, 32'd6, 32'h0, lat);
    checks++;
    if (lat !== 3) begin failures++; $display("FAIL nr_latency got=%0d want=3", lat); end
    checks++;
    if (a_din !== 32'h0000_1122) begin failures++; $display("FAIL nr16_a6 got=%h want=00001122", a_din); end
    checks++;
    if (last_rd_addr32 !== 32'd1) begin failures++; $display("FAIL nr_ram_addr got=%0d want=1", last_rd_addr32); end
    req32(1'b1, 1'b0, 2'b10, 32'd7, 32'h0, lat);
    checks++;
    if (a_din !== 32'h0000_1122) begin failures++; $display("FAIL nr16_a7 got=%h want=00001122", a_din); end
    req32(1'b1, 1'b0, 2'b11, 32'd4, 32'h0, lat);
    checks++;
    if (a_din !== 32'h0000_0044) begin failures++; $display("FAIL nr8_a4 got=%h want=00000044", a_din); end
    req32(1'b1, 1'b0, 2'b11, 32'd6, 32'h0, lat);
    checks++;
    if (a_din !== 32'h0000_0022) begin failures++; $display("FAIL nr8_a6 got=%h want=00000022", a_din); end
  endtask

  task automatic test_full_write;
    int lat, rd0, wr0;
    rd0 = n_rd32; wr0 = n_wr32;
    req32(1'b0, 1'b1, 2'b01, 32'd8, 32'hDEAD_BEEF, lat);
    checks++;
    if (lat !== 1) begin failures++; $display("FAIL fw_latency got=%0d want=1", lat); end
    checks++;
    if (mem32[2] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL fw_word got=%h want=deadbeef", mem32[2]); end
    checks++;
    if (n_rd32 - rd0 !== 0 || n_wr32 - wr0 !== 1) begin
      failures++; $display("FAIL fw_ram_ops rd=%0d wr=%0d want=0/1", n_rd32 - rd0, n_wr32 - wr0);
    end
    req32(1'b1, 1'b0, 2'b00, 32'd9, 32'h0, lat);
    checks++;
    if (a_din !== 32'hDEAD_BEEF || lat !== 3) begin
      failures++; $display("FAIL fr_word got=%h lat=%0d want=deadbeef lat=3", a_din, lat);
    end
  endtask

  task automatic test_ws16;
    int lat;
    req16(1'b1, 1'b0, 2'b01, 16'd2, 16'h0, lat);
    checks++;
    if (b_din !== 16'hCAFE || lat !== 3) begin
      failures++; $display("FAIL ws16_full_read got=%h lat=%0d want=cafe lat=3", b_din, lat);
    end
    req16(1'b1, 1'b1, 2'b00, 16'd4, 16'h1234, lat);
    checks++;
    if (mem16[2] !== 16'h1234 || lat !== 1) begin
      failures++; $display("FAIL ws16_rw_both word=%h lat=%0d want=1234 lat=1", mem16[2], lat);
    end
    checks++;
    if (b_din !== 16'hCAFE) begin failures++; $display("FAIL ws16_din_kept got=%h want=cafe", b_din); end
    req16(1'b1, 1'b0, 2'b11, 16'd3, 16'h0, lat);
    checks++;
    if (b_din !== 16'h00CA) begin failures++; $display("FAIL ws16_byte_read got=%h want=00ca", b_din); end
  endtask

  task automatic test_busy_ignore;
    int lat;
    @(negedge clk);
    while (a_ready || a_busy) @(negedge clk);
    a_wr = 1'b1; a_bits = 2'b10; a_addr = 32'd0; a_dout = 32'h0000_5566;
    @(posedge clk); #1;
    a_wr = 1'b0;
    checks++;
    if (a_busy !== 1'b1) begin failures++; $display("FAIL busy_high got=%b want=1", a_busy); end
    @(negedge clk);
    a_wr = 1'b1; a_bits = 2'b00; a_addr = 32'd12; a_dout = 32'hFFFF_FFFF;
    @(negedge clk);
    a_wr = 1'b0;
    lat = 2;
    while (!a_ready && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat !== 4) begin failures++; $display("FAIL busy_latency got=%0d want=4", lat); end
    @(posedge clk); #1;
    checks++;
    if (mem32[0] !== 32'hA0B0_5566 || mem32[3] !== 32'h0) begin
      failures++; $display("FAIL busy_ignore w0=%h w3=%h want=a0b05566/0", mem32[0], mem32[3]);
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    @(negedge clk);
    while (a_ready || a_busy) @(negedge clk);
    a_wr = 1'b1; a_bits = 2'b11; a_addr = 32'd4; a_dout = 32'h99;
    @(posedge clk); #1;
    a_wr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (a_ram_we !== 1'b1) begin failures++; $display("FAIL rm_in_merge got=%b want=1", a_ram_we); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({a_ram_en, a_ram_we, a_ready, a_busy} !== 4'b0000) begin
      failures++; $display("FAIL rm_cancel got=%b want=0000", {a_ram_en, a_ram_we, a_ready, a_busy});
    end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++;
      if (a_ready !== 1'b0) begin failures++; $display("FAIL rm_no_ready got=%b want=0", a_ready); end
    end
    @(negedge clk); rst_n = 1'b1;
    #1;
    checks++;
    if (mem32[1] !== 32'h1122AB44 || a_din !== 32'h0) begin
      failures++; $display("FAIL rm_after word=%h din=%h want=1122ab44/0", mem32[1], a_din);
    end
    req32(1'b1, 1'b0, 2'b11, 32'd4, 32'h0, lat);
    checks++;
    if (a_din !== 32'h44 || lat !== 3) begin
      failures++; $display("FAIL rm_next_read got=%h lat=%0d want=44 lat=3", a_din, lat);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem32[i] = 32'h0;
    for (int i = 0; i < 8; i++) mem16[i] = 16'h0;
    mem32[0] = 32'hA0B0_C0D0;
    mem32[1] = 32'h1122_3344;
    mem16[1] = 16'hCAFE;
    a_ram_din = '0; b_ram_din = '0;
    test_reset;
    test_narrow_write;
    test_narrow_read;
    test_full_write;
    test_ws16;
    test_busy_ignore;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
